uplus_40g_tx_frame_gen: RTL



---
 rtl/uplus_40g_tx_frame_gen.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/uplus_40g_tx_frame_gen.sv
// uplus_40g_tx_frame_gen
// Builds Ethernet frames (dst MAC, src MAC, EtherType, seeded byte pattern,
// zero padding up to the minimum length) and streams them on a 256-bit
// AXI-Stream port toward the 40G MAC, which appends the FCS.
module uplus_40g_tx_frame_gen #(
   parameter logic [7:0]  P_MIN_LENGTH = 8'd64,
   parameter logic [14:0] P_MAX_LENGTH = 15'd9600
) (
   input  logic         i_tx_clk,
   input  logic         i_tx_rst_n,
   input  logic         i_link_up,
   input  logic         i_req_valid,
   output logic         o_req_ready,
   input  logic [14:0]  i_req_len,
   input  logic [47:0]  i_req_dst_mac,
   input  logic [47:0]  i_req_src_mac,
   input  logic [15:0]  i_req_type,
   input  logic [7:0]   i_req_seed,
   input  logic         tx_axis_tready,
   output logic         tx_axis_tvalid,
   output logic [255:0] tx_axis_tdata,
   output logic [31:0]  tx_axis_tkeep,
   output logic         tx_axis_tlast,
   output logic         tx_axis_tuser,
   output logic         o_busy,
   output logic [31:0]  o_frame_cnt,
   output logic [15:0]  o_drop_cnt
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   // Content of one 32-byte beat; bytes at or beyond the requested length are 0,
   // which also covers padding and the unused tail of the last beat.
   function automatic logic [255:0] f_beat_data(
      input logic [8:0]  beat,
      input logic [47:0] dst,
      input logic [47:0] src,
      input logic [15:0] etype,
      input logic [7:0]  seed,
      input logic [14:0] len
   );
      logic [255:0] d;
      logic [14:0]  k;
      logic [7:0]   b;
      d = 256'd0;
      for (int j = 0; j < 32; j++) begin
         k = {1'b0, beat, 5'd0} + 15'(j);
         if (k < 15'd14) begin
            case (k[3:0])
               4'd0:    b = dst[47:40];
               4'd1:    b = dst[39:32];
               4'd2:    b = dst[31:24];
               4'd3:    b = dst[23:16];
               4'd4:    b = dst[15:8];
               4'd5:    b = dst[7:0];
               4'd6:    b = src[47:40];
               4'd7:    b = src[39:32];
               4'd8:    b = src[31:24];
               4'd9:    b = src[23:16];
               4'd10:   b = src[15:8];
               4'd11:   b = src[7:0];
               4'd12:   b = etype[15:8];
               4'd13:   b = etype[7:0];
               default: b = 8'h00;
            endcase
         end else if (k < len) begin
            b = seed + 8'(k - 15'd14);
         end else begin
            b = 8'h00;
         end
         d[8*j +: 8] = b;
      end
      return d;
   endfunction

   // Byte enables of the final beat from the padded length modulo 32.
   function automatic logic [31:0] f_last_keep(input logic [4:0] rem);
      if (rem == 5'd0) begin
         return 32'hFFFF_FFFF;
      end else begin
         return (32'd1 << rem) - 32'd1;
      end
   endfunction

   state_t        r_state;
   logic [47:0]   r_dst;
   logic [47:0]   r_src;
   logic [15:0]   r_type;
   logic [7:0]    r_seed;
   logic [14:0]   r_len;
   logic [8:0]    r_nbeats;
   logic [31:0]   r_last_keep;
   logic [8:0]    r_beat;
   logic          r_tvalid;
   logic [255:0]  r_tdata;
   logic [31:0]   r_tkeep;
   logic          r_tlast;
   logic          r_busy;
   logic          r_req_ready;
   logic [31:0]   r_frame_cnt;
   logic [15:0]   r_drop_cnt;
   logic          r_drop_pend;

   logic          w_accept;
   logic          w_len_bad;
   logic [14:0]   w_L;
   logic [8:0]    w_nbeats;
   logic [31:0]   w_last_keep;
   logic [8:0]    w_sel_beat;
   logic [47:0]   w_sel_dst;
   logic [47:0]   w_sel_src;
   logic [15:0]   w_sel_type;
   logic [7:0]    w_sel_seed;
   logic [14:0]   w_sel_len;
   logic [8:0]    w_sel_nbeats;
   logic [31:0]   w_sel_last_keep;
   logic [255:0]  w_beat_data;
   logic [31:0]   w_beat_keep;
   logic          w_beat_last;
   logic          w_handshake;

   assign w_accept    = i_req_valid & r_req_ready;
   assign w_handshake = r_tvalid & tx_axis_tready;
   assign w_len_bad   = (i_req_len == 15'd0) | (i_req_len > P_MAX_LENGTH);
   assign w_L         = (i_req_len < {7'd0, P_MIN_LENGTH}) ? {7'd0, P_MIN_LENGTH} : i_req_len;
   assign w_nbeats    = 9'(w_L[14:5]) + {8'd0, (w_L[4:0] != 5'd0)};
   assign w_last_keep = f_last_keep(w_L[4:0]);

   // Next beat to load: beat 0 straight from the request when idle, else the
   // beat after the one currently presented, from the captured fields.
   always_comb begin
      w_sel_beat      = 9'd0;
      w_sel_dst       = 48'd0;
      w_sel_src       = 48'd0;
      w_sel_type      = 16'd0;
      w_sel_seed      = 8'd0;
      w_sel_len       = 15'd0;
      w_sel_nbeats    = 9'd0;
      w_sel_last_keep = 32'd0;
      if (r_state == ST_IDLE) begin
         w_sel_beat      = 9'd0;
         w_sel_dst       = i_req_dst_mac;
         w_sel_src       = i_req_src_mac;
         w_sel_type      = i_req_type;
         w_sel_seed      = i_req_seed;
         w_sel_len       = i_req_len;
         w_sel_nbeats    = w_nbeats;
         w_sel_last_keep = w_last_keep;
      end else begin
         w_sel_beat      = r_beat + 9'd1;
         w_sel_dst       = r_dst;
         w_sel_src       = r_src;
         w_sel_type      = r_type;
         w_sel_seed      = r_seed;
         w_sel_len       = r_len;
         w_sel_nbeats    = r_nbeats;
         w_sel_last_keep = r_last_keep;
      end
      w_beat_data = f_beat_data(w_sel_beat, w_sel_dst, w_sel_src, w_sel_type, w_sel_seed, w_sel_len);
      w_beat_last = (w_sel_beat == (w_sel_nbeats - 9'd1));
      if (w_beat_last) begin
         w_beat_keep = w_sel_last_keep;
      end else begin
         w_beat_keep = 32'hFFFF_FFFF;
      end
   end

   // Frame FSM, counters and registered AXIS outputs.
   always_ff @(posedge i_tx_clk) begin
      if (!i_tx_rst_n) begin
         r_state     <= ST_IDLE;
         r_dst       <= 48'd0;
         r_src       <= 48'd0;
         r_type      <= 16'd0;
         r_seed      <= 8'd0;
         r_len       <= 15'd0;
         r_nbeats    <= 9'd0;
         r_last_keep <= 32'd0;
         r_beat      <= 9'd0;
         r_tvalid    <= 1'b0;
         r_tdata     <= 256'd0;
         r_tkeep     <= 32'd0;
         r_tlast     <= 1'b0;
         r_busy      <= 1'b0;
         r_req_ready <= 1'b0;
         r_frame_cnt <= 32'd0;
         r_drop_cnt  <= 16'd0;
         r_drop_pend <= 1'b0;
      end else begin
         r_drop_pend <= 1'b0;
         // A rejected request is counted one edge after it was accepted.
         if (r_drop_pend && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
         end
         case (r_state)
            ST_IDLE: begin
               r_req_ready <= i_link_up;
               r_busy      <= 1'b0;
               if (w_accept) begin
                  if (w_len_bad) begin
                     r_drop_pend <= 1'b1;
                  end else begin
                     r_dst       <= i_req_dst_mac;
                     r_src       <= i_req_src_mac;
                     r_type      <= i_req_type;
                     r_seed      <= i_req_seed;
                     r_len       <= i_req_len;
                     r_nbeats    <= w_nbeats;
                     r_last_keep <= w_last_keep;
                     r_beat      <= 9'd0;
                     r_tvalid    <= 1'b1;
                     r_tdata     <= w_beat_data;
                     r_tkeep     <= w_beat_keep;
                     r_tlast     <= w_beat_last;
                     r_busy      <= 1'b1;
                     r_req_ready <= 1'b0;
                     r_state     <= ST_SEND;
                  end
               end
            end
            ST_SEND: begin
               r_req_ready <= 1'b0;
               if (w_handshake) begin
                  if (r_tlast) begin
                     r_tvalid    <= 1'b0;
                     r_tdata     <= 256'd0;
                     r_tkeep     <= 32'd0;
                     r_tlast     <= 1'b0;
                     r_busy      <= 1'b0;
                     r_req_ready <= i_link_up;
                     r_frame_cnt <= r_frame_cnt + 32'd1;
                     r_state     <= ST_IDLE;
                  end else begin
                     r_beat  <= r_beat + 9'd1;
                     r_tdata <= w_beat_data;
                     r_tkeep <= w_beat_keep;
                     r_tlast <= w_beat_last;
                  end
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_tvalid    <= 1'b0;
               r_tlast     <= 1'b0;
               r_busy      <= 1'b0;
               r_req_ready <= 1'b0;
            end
         endcase
      end
   end

   assign o_req_ready    = r_req_ready;
   assign tx_axis_tvalid = r_tvalid;
   assign tx_axis_tdata  = r_tdata;
   assign tx_axis_tkeep  = r_tkeep;
   assign tx_axis_tlast  = r_tlast;
   assign tx_axis_tuser  = 1'b0;
   assign o_busy         = r_busy;
   assign o_frame_cnt    = r_frame_cnt;
   assign o_drop_cnt     = r_drop_cnt;

endmodule
